quadrant_histogram: RTL
=======================

QUADRANT_HISTOGRAM -- requirements
Module: quadrant_histogram

Interface
REQ-001 Parameter WIN, default 8: quadrant codes accumulated per window (2..255).
REQ-002 Parameter CW, default 4: per-quadrant counter width; counters saturate at 2^CW-1.
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset_  input  1  reset is synchronous and active-low; sampled on posedge clock.
REQ-005 q  input  2  quadrant code from upstream stage; valid when done is high.
REQ-006 done  input  1  upstream completion pulse; each rising edge marks one new q.
REQ-007 cnt  output  CW  count being presented downstream.
REQ-008 idx  output  2  quadrant index (0..3) of cnt.
REQ-009 dav_  output  1  active-low data-available to downstream.
REQ-010 rfd  input  1  ready-for-data from downstream (1 = ready, 0 = accepted).
REQ-011 ovr  output  1  sticky overrun flag.

Function
REQ-012 Sample capture: done_d register holds done of previous cycle; a sample event occurs on a cycle where done==1 and done_d==0; q is captured on that same edge.
REQ-013 Two banks of four CW-bit counters (A, B); one bank is active (accumulating), the other is the drain bank; after reset A is active.
REQ-014 Each sample event increments active[q] by 1, saturating at 2^CW-1; a window sample counter wcnt (8-bit) increments by 1.
REQ-015 Window close: the sample event that makes wcnt reach WIN is counted in the closing bank; on that edge wcnt clears to 0.
REQ-016 If the drain FSM is in D_IDLE at window close: banks swap roles on that edge, new active bank is cleared to zero, drain FSM enters D_PRES with idx=0.
REQ-017 If the drain FSM is not in D_IDLE at window close: ovr sets to 1, active bank clears to zero, no swap, drain continues undisturbed (closed window data discarded).
REQ-018 ovr stays 1 until reset.
REQ-019 Drain FSM states: D_IDLE, D_PRES, D_ACK.
REQ-020 D_IDLE: dav_=1; leaves only per REQ-016.
REQ-021 D_PRES: cnt=drain[idx], dav_=0; if rfd==0 go D_ACK, else stay.
REQ-022 D_ACK: dav_=1, cnt/idx held; if rfd==1: idx==3 -> D_IDLE, else idx+1 and D_PRES; else stay.
REQ-023 Four-phase handshake: cnt and idx stable for the whole time dav_==0 and until rfd returns to 1.
REQ-024 Latency: dav_ goes low on the first posedge after the window-closing edge (registered outputs).
REQ-025 A sample event in the same cycle as drain activity is always counted into the active bank; accumulation never stalls.
REQ-026 done held high for multiple cycles counts as one sample; done must return low for at least one cycle between samples.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 While reset_==0 at posedge clock: both banks=0, wcnt=0, done_d=0, A active, drain FSM=D_IDLE, dav_=1, idx=0, cnt=0, ovr=0.
REQ-029 Reset asserted mid-window or mid-drain aborts all activity; no partial transfer completes; first post-reset sample starts a fresh window.

Verification
REQ-030 WIN=8, codes 0,1,2,3,0,1,2,3 each as 1-cycle done pulse, downstream acks promptly -> four transfers idx 0..3 each cnt=2, dav_ low 1 cycle after 8th pulse, ovr=0.
REQ-031 Eight samples all q=2 -> transfers idx0=0, idx1=0, idx2=8, idx3=0; with CW=3 idx2 saturates to 7.
REQ-032 Downstream holds rfd=1 (never accepts) while 16 samples arrive -> first window stays presented at idx 0, dav_=0, ovr=1 after 16th sample, cnt unchanged.
REQ-033 Samples arriving during drain of window 1 (prompt acks) -> window 2 counts correct and drained after window 1 completes, ovr=0.
REQ-034 done held high 5 cycles -> exactly one sample counted.
REQ-035 reset_ low for one cycle while dav_=0 at idx=2 -> next posedge dav_=1, idx=0, cnt=0, ovr=0; next 8 samples produce a clean window.

Source files
------------

// File: rtl/quadrant_histogram.sv
// Windowed histogram of 2-bit quadrant codes: two ping-pong banks of saturating
// counters, with the closed window drained over a four-phase dav_/rfd handshake.
module quadrant_histogram #(
  parameter int unsigned WIN = 8,
  parameter int unsigned CW  = 4
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic [1:0]    q,
  input  logic          done,
  output logic [CW-1:0] cnt,
  output logic [1:0]    idx,
  output logic          dav_,
  input  logic          rfd,
  output logic          ovr
);

  typedef enum logic [1:0] {D_IDLE, D_PRES, D_ACK} dstate_t;

  localparam logic [7:0] WIN_CNT = 8'(WIN);

  logic [3:0][CW-1:0] bank [2];
  logic               act;
  logic               done_d;
  logic [7:0]         wcnt;
  dstate_t            state;
  logic [1:0]         ptr;

  logic               sample;
  logic               close;
  logic [CW-1:0]      cur;
  logic [CW-1:0]      inc;

  always_comb begin
    sample = done & ~done_d;
    close  = sample && ((wcnt + 8'd1) == WIN_CNT);
    cur    = bank[act][q];
    inc    = (cur == '1) ? cur : cur + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      bank[0] <= '0;
      bank[1] <= '0;
      act     <= 1'b0;
      done_d  <= 1'b0;
      wcnt    <= '0;
      state   <= D_IDLE;
      ptr     <= '0;
      cnt     <= '0;
      idx     <= '0;
      dav_    <= 1'b1;
      ovr     <= 1'b0;
    end else begin
      done_d <= done;

      // The closing sample lands in the bank that becomes the drain bank;
      // on overrun that whole window is dropped with the cleared active bank.
      if (sample) begin
        if (close) begin
          wcnt <= '0;
          if (state == D_IDLE) begin
            bank[act][q] <= inc;
            bank[~act]   <= '0;
            act          <= ~act;
            ptr          <= '0;
            state        <= D_PRES;
          end else begin
            bank[act] <= '0;
            ovr       <= 1'b1;
          end
        end else begin
          wcnt         <= wcnt + 8'd1;
          bank[act][q] <= inc;
        end
      end

      case (state)
        D_PRES: if (!rfd) state <= D_ACK;
        D_ACK: begin
          if (rfd) begin
            if (ptr == 2'd3) begin
              state <= D_IDLE;
            end else begin
              ptr   <= ptr + 2'd1;
              state <= D_PRES;
            end
          end
        end
        default: ;
      endcase

      // Outputs trail the state by one edge, so cnt/idx are loaded together
      // with dav_ falling and frozen until the next presentation.
      if (state == D_PRES) begin
        dav_ <= 1'b0;
        cnt  <= bank[~act][ptr];
        idx  <= ptr;
      end else begin
        dav_ <= 1'b1;
      end
    end
  end

endmodule
